// File: rtl/stopwatch_dp_pkg.sv
// Shared stopwatch constants: time moduli, display field widths and default clocking.
// Used by the control FSM, this datapath and the display formatting stage.
package stopwatch_dp_pkg;

  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int TICK_HZ_DEF  = 100;

  localparam int MSEC_MAX_DEF = 100;
  localparam int SEC_MAX_DEF  = 60;
  localparam int MIN_MAX_DEF  = 60;
  localparam int HOUR_MAX_DEF = 24;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_time_counter.sv
// One modulo-MAX time field; o_carry flags the increment that wraps it back to 0.
module stopwatch_time_counter #(
  parameter int MAX   = 100,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);

  logic at_max;

  assign at_max  = (o_count == WIDTH'(MAX - 1));
  assign o_carry = i_inc & at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= at_max ? '0 : o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaler producing the centisecond tick and a single-edge
// carry cascade of msec/sec/min/hour counters.
module stopwatch_dp
  import stopwatch_dp_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int TICK_HZ  = TICK_HZ_DEF,
  parameter int MSEC_MAX = MSEC_MAX_DEF,
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_runstop,
  input  logic              i_clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_at_max;
  logic          msec_carry;
  logic          sec_carry;
  logic          min_carry;

  assign presc_at_max = (presc == PW'(DIV - 1));
  assign o_tick       = i_runstop & ~i_clear & presc_at_max;

  // Stop simply freezes presc so a resumed run finishes the partial centisecond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (i_clear) begin
      presc <= '0;
    end else if (i_runstop) begin
      presc <= presc_at_max ? '0 : presc + PW'(1);
    end
  end

  stopwatch_time_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_inc(o_tick),
    .o_count(o_msec), .o_carry(msec_carry)
  );

  stopwatch_time_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_inc(msec_carry),
    .o_count(o_sec), .o_carry(sec_carry)
  );

  stopwatch_time_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_inc(sec_carry),
    .o_count(o_min), .o_carry(min_carry)
  );

  // Day wrap has no consumer, so the hour carry is left open.
  stopwatch_time_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_inc(min_carry),
    .o_count(o_hour), .o_carry()
  );

endmodule

// File: tb/tb_stopwatch_dp.sv
// Directed bench: DIV=10 instance (a), DIV=1 instance (b), DIV=1 with tiny moduli (c).
module tb_stopwatch_dp;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       runstop_a = 1'b0, clear_a = 1'b0;
  logic [6:0] msec_a;
  logic [5:0] sec_a, min_a;
  logic [4:0] hour_a;
  logic       tick_a;

  logic       runstop_b = 1'b0, clear_b = 1'b0;
  logic [6:0] msec_b;
  logic [5:0] sec_b, min_b;
  logic [4:0] hour_b;
  logic       tick_b;

  logic       runstop_c = 1'b0, clear_c = 1'b0;
  logic [6:0] msec_c;
  logic [5:0] sec_c, min_c;
  logic [4:0] hour_c;
  logic       tick_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut_a (
    .clk(clk), .rst(rst), .i_runstop(runstop_a), .i_clear(clear_a),
    .o_msec(msec_a), .o_sec(sec_a), .o_min(min_a), .o_hour(hour_a), .o_tick(tick_a)
  );

  stopwatch_dp #(.CLK_FREQ(100), .TICK_HZ(100)) dut_b (
    .clk(clk), .rst(rst), .i_runstop(runstop_b), .i_clear(clear_b),
    .o_msec(msec_b), .o_sec(sec_b), .o_min(min_b), .o_hour(hour_b), .o_tick(tick_b)
  );

  stopwatch_dp #(.CLK_FREQ(100), .TICK_HZ(100), .MSEC_MAX(4), .SEC_MAX(3),
                 .MIN_MAX(3), .HOUR_MAX(2)) dut_c (
    .clk(clk), .rst(rst), .i_runstop(runstop_c), .i_clear(clear_c),
    .o_msec(msec_c), .o_sec(sec_c), .o_min(min_c), .o_hour(hour_c), .o_tick(tick_c)
  );

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clear_a = 1'b1; runstop_a = 1'b1; #1;
    edges(1);
    clear_a = 1'b0;
    edges(59);
    checks++;
    if (msec_a !== 7'd5 || tick_a !== 1'b1) begin
      $display("FAIL reset_prerun: msec=%0d tick=%0d, want msec=5 tick=1", msec_a, tick_a);
      failures++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({hour_a, min_a, sec_a, msec_a, tick_a} !== '0) begin
      $display("FAIL reset_async: %0d:%0d:%0d.%0d tick=%0d, want all 0",
               hour_a, min_a, sec_a, msec_a, tick_a);
      failures++;
    end
    edges(2);
    checks++;
    if ({hour_a, min_a, sec_a, msec_a, tick_a} !== '0) begin
      $display("FAIL reset_hold: msec=%0d tick=%0d, want 0", msec_a, tick_a);
      failures++;
    end
    rst = 1'b1;
    edges(9);
    checks++;
    if (msec_a !== 7'd0 || tick_a !== 1'b1) begin
      $display("FAIL reset_release_9: msec=%0d tick=%0d, want msec=0 tick=1", msec_a, tick_a);
      failures++;
    end
    edges(1);
    checks++;
    if (msec_a !== 7'd1) begin
      $display("FAIL reset_release_10: msec=%0d, want 1", msec_a);
      failures++;
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_count;
    int ticks = 0;
    int first = -1;
    clear_a = 1'b1; runstop_a = 1'b1; #1;
    edges(1);
    clear_a = 1'b0; #1;
    for (int i = 1; i <= 100; i++) begin
      if (tick_a === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
      edges(1);
    end
    checks++;
    if (ticks != 10 || first != 10) begin
      $display("FAIL basic_tick_rate: ticks=%0d first=%0d, want ticks=10 first=10", ticks, first);
      failures++;
    end
    checks++;
    if (msec_a !== 7'd10 || sec_a !== 6'd0) begin
      $display("FAIL basic_100: sec=%0d msec=%0d, want 0.10", sec_a, msec_a);
      failures++;
    end
    edges(900);
    checks++;
    if (msec_a !== 7'd0 || sec_a !== 6'd1 || min_a !== 6'd0) begin
      $display("FAIL basic_1000: min=%0d sec=%0d msec=%0d, want 0:01.00", min_a, sec_a, msec_a);
      failures++;
    end
    $display("test_basic_count done");
  endtask

  task automatic test_hold_resume;
    int bad = 0;
    int first = -1;
    clear_a = 1'b1; runstop_a = 1'b1; #1;
    edges(1);
    clear_a = 1'b0;
    edges(25);
    runstop_a = 1'b0; #1;
    repeat (37) begin
      if (tick_a !== 1'b0) bad++;
      edges(1);
    end
    checks++;
    if (bad != 0 || msec_a !== 7'd2 || sec_a !== 6'd0) begin
      $display("FAIL hold: tick_high=%0d msec=%0d sec=%0d, want 0/2/0", bad, msec_a, sec_a);
      failures++;
    end
    runstop_a = 1'b1; #1;
    for (int i = 1; i <= 5; i++) begin
      if (tick_a === 1'b1 && first < 0) first = i;
      if (i == 5) begin
        checks++;
        if (msec_a !== 7'd2) begin
          $display("FAIL resume_4: msec=%0d, want 2", msec_a);
          failures++;
        end
      end
      edges(1);
    end
    checks++;
    if (first != 5 || msec_a !== 7'd3) begin
      $display("FAIL resume_tick: first=%0d msec=%0d, want first=5 msec=3", first, msec_a);
      failures++;
    end
    $display("test_hold_resume done");
  endtask

  task automatic test_clear;
    clear_a = 1'b1; runstop_a = 1'b1; #1;
    edges(1);
    clear_a = 1'b0;
    edges(3429);
    checks++;
    if (sec_a !== 6'd3 || msec_a !== 7'd42 || tick_a !== 1'b1) begin
      $display("FAIL clear_pre: sec=%0d msec=%0d tick=%0d, want 3.42 tick=1", sec_a, msec_a, tick_a);
      failures++;
    end
    clear_a = 1'b1; #1;
    checks++;
    if (tick_a !== 1'b0) begin
      $display("FAIL clear_tick: tick=%0d, want 0", tick_a);
      failures++;
    end
    edges(1);
    checks++;
    if ({hour_a, min_a, sec_a, msec_a, tick_a} !== '0) begin
      $display("FAIL clear_zero: %0d:%0d:%0d.%0d tick=%0d, want all 0",
               hour_a, min_a, sec_a, msec_a, tick_a);
      failures++;
    end
    clear_a = 1'b0;
    edges(9);
    checks++;
    if (msec_a !== 7'd0 || tick_a !== 1'b1) begin
      $display("FAIL clear_restart_9: msec=%0d tick=%0d, want msec=0 tick=1", msec_a, tick_a);
      failures++;
    end
    edges(1);
    checks++;
    if (msec_a !== 7'd1) begin
      $display("FAIL clear_restart_10: msec=%0d, want 1", msec_a);
      failures++;
    end
    $display("test_clear done");
  endtask

  task automatic test_toggle_div1;
    int bad = 0;
    clear_b = 1'b1; runstop_b = 1'b1; #1;
    edges(1);
    clear_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      runstop_b = (i % 2 == 0);
      #1;
      if (tick_b !== runstop_b) bad++;
      edges(1);
    end
    checks++;
    if (bad != 0 || sec_b !== 6'd1 || msec_b !== 7'd0) begin
      $display("FAIL toggle_div1: tick_errs=%0d sec=%0d msec=%0d, want 0 errs, 1.00",
               bad, sec_b, msec_b);
      failures++;
    end
    $display("test_toggle_div1 done");
  endtask

  task automatic test_sec_to_min;
    runstop_b = 1'b1; #1;
    edges(5899);
    checks++;
    if (min_b !== 6'd0 || sec_b !== 6'd59 || msec_b !== 7'd99) begin
      $display("FAIL sec_wrap_pre: %0d:%0d.%0d, want 0:59.99", min_b, sec_b, msec_b);
      failures++;
    end
    edges(1);
    checks++;
    if (hour_b !== 5'd0 || min_b !== 6'd1 || sec_b !== 6'd0 || msec_b !== 7'd0) begin
      $display("FAIL sec_wrap: %0d:%0d:%0d.%0d, want 0:1:00.00", hour_b, min_b, sec_b, msec_b);
      failures++;
    end
    $display("test_sec_to_min done");
  endtask

  task automatic test_full_rollover;
    clear_c = 1'b1; runstop_c = 1'b1; #1;
    edges(1);
    clear_c = 1'b0;
    edges(11);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== {5'd0, 6'd0, 6'd2, 7'd3}) begin
      $display("FAIL roll_11: %0d:%0d:%0d.%0d, want 0:0:2.3", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    edges(1);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== {5'd0, 6'd1, 6'd0, 7'd0}) begin
      $display("FAIL roll_12: %0d:%0d:%0d.%0d, want 0:1:0.0", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    edges(23);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== {5'd0, 6'd2, 6'd2, 7'd3}) begin
      $display("FAIL roll_35: %0d:%0d:%0d.%0d, want 0:2:2.3", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    edges(1);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== {5'd1, 6'd0, 6'd0, 7'd0}) begin
      $display("FAIL roll_36: %0d:%0d:%0d.%0d, want 1:0:0.0", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    edges(35);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== {5'd1, 6'd2, 6'd2, 7'd3}) begin
      $display("FAIL roll_71: %0d:%0d:%0d.%0d, want 1:2:2.3", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    edges(1);
    checks++;
    if ({hour_c, min_c, sec_c, msec_c} !== '0) begin
      $display("FAIL roll_72: %0d:%0d:%0d.%0d, want 0:0:0.0", hour_c, min_c, sec_c, msec_c);
      failures++;
    end
    $display("test_full_rollover done");
  endtask

  initial begin
    rst = 1'b0;
    edges(3);
    checks++;
    if ({hour_a, min_a, sec_a, msec_a, tick_a} !== '0) begin
      $display("FAIL power_on_reset: %0d:%0d:%0d.%0d tick=%0d, want all 0",
               hour_a, min_a, sec_a, msec_a, tick_a);
      failures++;
    end
    rst = 1'b1;
    edges(1);
    test_reset();
    test_basic_count();
    test_hold_resume();
    test_clear();
    test_toggle_div1();
    test_sec_to_min();
    test_full_rollover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
